// File: rtl/jam_search.sv
// jam_search: exhaustive job-assignment solver.
// Steps through every permutation of N jobs over N workers in lexicographic
// order. Each worker/job cost is read from an external combinational ROM.
// The block reports the minimum total cost, how many assignments reach it,
// and the first minimal assignment.
//
// Ports
//   CLK        : clock, rising edge
//   RST        : synchronous reset, active-high (has priority over Start)
//   Start      : restart request, honoured only while results are valid
//   W, J       : registered ROM worker/job address
//   Cost       : ROM data for the current W/J, sampled at the next edge
//   MatchCount : number of assignments whose total equals MinCost
//   MinCost    : minimum assignment total
//   BestSeq    : first minimal assignment, [i*IDX_W +: IDX_W] = job of worker i
//   Valid      : results final; held until restart or reset
module jam_search #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic [SUM_W-1:0]     MinCost,
    output logic [N*IDX_W-1:0]   BestSeq,
    output logic                 Valid
);

    typedef enum logic [1:0] {S_RUN, S_EVAL, S_DONE} state_e;
    typedef logic [N-1:0][IDX_W-1:0] perm_t;

    state_e           state_q, state_d;
    perm_t            perm_q, perm_d, bestseq_q, bestseq_d;
    perm_t            perm_id, perm_sw, perm_nxt;
    logic [SUM_W-1:0] sum_q, sum_d, best_q, best_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, w_q, w_d, j_q, j_d;
    logic [IDX_W-1:0] piv, swp;
    logic             has_next;

    always_comb begin
        perm_id = '0;
        for (int m = 0; m < N; m++) perm_id[m] = IDX_W'(m);
    end

    // Next lexicographic permutation of perm_q, in one cycle.
    // piv: rightmost ascent; swp: rightmost element past piv larger than it.
    // After the swap the suffix past piv is descending, so reversing it
    // gives the smallest successor. No ascent means this is the last one.
    always_comb begin
        has_next = 1'b0;
        piv      = '0;
        swp      = '0;
        for (int a = 0; a < N - 1; a++) begin
            if (perm_q[a] < perm_q[a+1]) begin
                has_next = 1'b1;
                piv      = IDX_W'(a);
            end
        end
        for (int b = 0; b < N; b++) begin
            if (IDX_W'(b) > piv && perm_q[b] > perm_q[piv]) swp = IDX_W'(b);
        end
        perm_sw      = perm_q;
        perm_sw[piv] = perm_q[swp];
        perm_sw[swp] = perm_q[piv];
        perm_nxt     = perm_sw;
        // Element m of the reversed suffix comes from position N+piv-m.
        // Modulo-2^IDX_W arithmetic is exact here because the result is < N.
        for (int m = 0; m < N; m++) begin
            if (IDX_W'(m) > piv) perm_nxt[m] = perm_sw[piv + IDX_W'(N - m)];
        end
        if (!has_next) perm_nxt = perm_q;
    end

    always_comb begin
        state_d   = state_q;
        perm_d    = perm_q;
        sum_d     = sum_q;
        best_d    = best_q;
        cnt_d     = cnt_q;
        bestseq_d = bestseq_q;
        idx_d     = idx_q;
        w_d       = w_q;
        j_d       = j_q;
        case (state_q)
            S_RUN: begin
                sum_d = sum_q + SUM_W'(Cost);
                if (idx_q == IDX_W'(N - 1)) begin
                    // Preload the first address of the next permutation so
                    // the ROM is ready when RUN resumes after EVAL.
                    state_d = S_EVAL;
                    w_d     = '0;
                    j_d     = perm_nxt[0];
                end else begin
                    idx_d = idx_q + 1'b1;
                    w_d   = idx_q + 1'b1;
                    j_d   = perm_q[idx_q + 1'b1];
                end
            end
            S_EVAL: begin
                // Strict less-than keeps the earliest minimal assignment.
                if (sum_q < best_q) begin
                    best_d    = sum_q;
                    cnt_d     = CNT_W'(1);
                    bestseq_d = perm_q;
                end else if (sum_q == best_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!has_next) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    perm_d  = perm_nxt;
                    sum_d   = '0;
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                if (Start) begin
                    state_d   = S_RUN;
                    perm_d    = perm_id;
                    sum_d     = '0;
                    best_d    = '1;
                    cnt_d     = '0;
                    bestseq_d = '0;
                    idx_d     = '0;
                    w_d       = '0;
                    j_d       = '0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_RUN;
            perm_q    <= perm_id;
            sum_q     <= '0;
            best_q    <= '1;
            cnt_q     <= '0;
            bestseq_q <= '0;
            idx_q     <= '0;
            w_q       <= '0;
            j_q       <= '0;
        end else begin
            state_q   <= state_d;
            perm_q    <= perm_d;
            sum_q     <= sum_d;
            best_q    <= best_d;
            cnt_q     <= cnt_d;
            bestseq_q <= bestseq_d;
            idx_q     <= idx_d;
            w_q       <= w_d;
            j_q       <= j_d;
        end
    end

    // Results are exposed only while final; they read as zero otherwise.
    assign Valid      = (state_q == S_DONE);
    assign MinCost    = Valid ? best_q : '0;
    assign MatchCount = Valid ? cnt_q : '0;
    assign BestSeq    = Valid ? bestseq_q : '0;
    assign W          = w_q;
    assign J          = j_q;

endmodule

// File: tb/tb_jam_search.sv
// Bench for jam_search at N=4: random and directed cost matrices, address
// order, Valid timing, restart, ignored Start, and mid-run reset.
module tb_jam_search;
    localparam int N      = 4;
    localparam int IDX_W  = 2;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int CNT_W  = 16;
    localparam int NPERM  = 24;
    localparam int RUNLEN = NPERM * (N + 1);

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               Start = 1'b0;
    logic [IDX_W-1:0]   W, J;
    logic [COST_W-1:0]  Cost;
    logic [CNT_W-1:0]   MatchCount;
    logic [SUM_W-1:0]   MinCost;
    logic [N*IDX_W-1:0] BestSeq;
    logic               Valid;

    logic [COST_W-1:0]  cm [N][N];
    int                 seq [NPERM][N];
    int                 errors = 0;
    int                 checks = 0;

    assign Cost = cm[W][J];

    jam_search #(.N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .W(W), .J(J), .Cost(Cost),
        .MatchCount(MatchCount), .MinCost(MinCost), .BestSeq(BestSeq), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All permutations in lexicographic order via nested loops over values.
    task automatic build_seq();
        int p = 0;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                for (int c = 0; c < N; c++)
                    for (int d = 0; d < N; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            seq[p][0] = a; seq[p][1] = b; seq[p][2] = c; seq[p][3] = d;
                            p++;
                        end
    endtask

    task automatic model(output int mn, output int cnt, output int bs);
        mn = 1 << 30; cnt = 0; bs = 0;
        for (int p = 0; p < NPERM; p++) begin
            int t = 0;
            for (int w = 0; w < N; w++) t += int'(cm[w][seq[p][w]]);
            if (t < mn) begin
                mn = t; cnt = 1; bs = 0;
                for (int w = 0; w < N; w++) bs |= seq[p][w] << (w * IDX_W);
            end else if (t == mn) cnt++;
        end
    endtask

    // kind: 0 random 0..hi, 1 diagonal zero, 2 anti-diagonal zero, 3 all ones, 4 (w+1)(j+1)
    task automatic set_mat(input int kind, input int hi);
        for (int w = 0; w < N; w++)
            for (int j = 0; j < N; j++)
                case (kind)
                    1:       cm[w][j] = (w == j) ? 7'd0 : 7'd10;
                    2:       cm[w][j] = (w + j == N - 1) ? 7'd0 : 7'd10;
                    3:       cm[w][j] = 7'd1;
                    4:       cm[w][j] = 7'((w + 1) * (j + 1));
                    default: cm[w][j] = 7'($urandom_range(0, hi));
                endcase
    endtask

    // Entered #1 after the edge that put the DUT at the first RUN cycle.
    task automatic do_run(input string tag, input int start_at);
        int e = 0, bad = 0, mn, cnt, bs;
        model(mn, cnt, bs);
        while (e <= RUNLEN + 20 && !Valid) begin
            if ((e % (N + 1)) < N && e / (N + 1) < NPERM) begin
                if (int'(W) != e % (N + 1) || int'(J) != seq[e / (N + 1)][e % (N + 1)]) bad++;
            end
            Start = (e == start_at);
            @(posedge CLK); #1;
            Start = 1'b0;
            e++;
        end
        check({tag, ".valid_edge"}, e, RUNLEN);
        check({tag, ".addr_order_errs"}, bad, 0);
        check({tag, ".MinCost"}, MinCost, mn);
        check({tag, ".MatchCount"}, MatchCount, cnt);
        check({tag, ".BestSeq"}, BestSeq, bs);
    endtask

    task automatic restart();
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        check("restart.Valid", Valid, 0);
        check("restart.MatchCount", MatchCount, 0);
    endtask

    initial begin
        build_seq();
        set_mat(0, 100);
        RST = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        check("rst.Valid", Valid, 0);
        check("rst.MinCost", MinCost, 0);
        check("rst.MatchCount", MatchCount, 0);
        check("rst.BestSeq", BestSeq, 0);
        check("rst.W", W, 0);
        check("rst.J", J, 0);
        RST = 1'b0;
        do_run("rand100", -1);

        repeat (7) @(posedge CLK);
        #1;
        check("hold.Valid", Valid, 1);
        begin
            int mn, cnt, bs;
            model(mn, cnt, bs);
            check("hold.MinCost", MinCost, mn);
        end

        // Small cost range makes ties likely; Start during RUN must be ignored.
        set_mat(0, 3);
        restart();
        do_run("rand3_startmid", 37);

        // Abort mid-run with a one-cycle reset.
        set_mat(1, 0);
        restart();
        repeat (50) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst.Valid", Valid, 0);
        check("midrst.MinCost", MinCost, 0);
        check("midrst.W", W, 0);
        check("midrst.J", J, 0);
        do_run("diag", -1);
        check("diag.BestSeq_const", BestSeq, 32'hE4);

        set_mat(2, 0);
        restart();
        do_run("antidiag", -1);
        check("antidiag.BestSeq_const", BestSeq, 32'h1B);

        set_mat(3, 0);
        restart();
        do_run("ones", -1);
        check("ones.MatchCount_const", MatchCount, 24);

        set_mat(4, 0);
        restart();
        do_run("prod", -1);
        check("prod.MinCost_const", MinCost, 20);

        for (int r = 0; r < 3; r++) begin
            set_mat(0, 2);
            restart();
            do_run("rand2", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
